// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC FSM state encoding and default datapath/gain constants
package cordic_pkg;
    typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_e;
    localparam int DEF_DATA_OP_WIDTH = 18;
    localparam int DEF_GAIN_WIDTH = 16;
    localparam logic [DEF_GAIN_WIDTH-1:0] DEF_INV_GAIN = 16'h9B75;
endpackage

// File: rtl/cordic_serial_mul.sv
// cordic_serial_mul: one bit-serial shift-add lane, MSB-first, with round-half-up result.
// Ports: i_clk/i_rst clock and sync reset; i_clr clears the accumulator; i_en steps one
// gain bit; i_bit is the current gain bit; i_op the signed operand; o_res the rounded product.
module cordic_serial_mul import cordic_pkg::*; #(
    parameter int DATA_OP_WIDTH = DEF_DATA_OP_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_clr,
    input  logic                            i_en,
    input  logic                            i_bit,
    input  logic signed [DATA_OP_WIDTH-1:0] i_op,
    output logic signed [DATA_OP_WIDTH-1:0] o_res
);
    localparam int AW = DATA_OP_WIDTH + GAIN_WIDTH + 1;
    logic signed [AW-1:0] acc_q, acc_d;
    always_comb begin
        acc_d = i_clr ? '0 : i_en ? (acc_q <<< 1) + (i_bit ? AW'(i_op) : '0) : acc_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) acc_q <= '0;
        else acc_q <= acc_d;
    end
    // adding half an LSB before the arithmetic shift rounds ties toward +inf
    assign o_res = DATA_OP_WIDTH'((acc_q + (AW'(1) <<< (GAIN_WIDTH - 1))) >>> GAIN_WIDTH);
endmodule

// File: rtl/cordic_post.sv
// cordic_post: CORDIC output stage removing the gain via serial multiply by 1/K, with flip and handshake.
// Ports: i_clk/i_rst clock and sync reset; i_valid/o_ready input handshake; i_func (0 rotation,
// 1 vectoring), i_flip, i_x/i_y/i_z raw stage results; o_valid/i_ready output handshake;
// o_x/o_y/o_z compensated results.
module cordic_post import cordic_pkg::*; #(
    parameter int DATA_OP_WIDTH = DEF_DATA_OP_WIDTH,
    parameter int FUNC_WIDTH = 1,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter logic [GAIN_WIDTH-1:0] INV_GAIN = DEF_INV_GAIN
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [FUNC_WIDTH-1:0]           i_func,
    input  logic                            i_flip,
    input  logic signed [DATA_OP_WIDTH-1:0] i_x,
    input  logic signed [DATA_OP_WIDTH-1:0] i_y,
    input  logic signed [DATA_OP_WIDTH-1:0] i_z,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic signed [DATA_OP_WIDTH-1:0] o_x,
    output logic signed [DATA_OP_WIDTH-1:0] o_y,
    output logic signed [DATA_OP_WIDTH-1:0] o_z
);
    localparam int IW = (GAIN_WIDTH > 1) ? $clog2(GAIN_WIDTH) : 1;
    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FUNC_WIDTH-1:0] func_q, func_d;
    logic flip_q, flip_d;
    logic signed [DATA_OP_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [DATA_OP_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic signed [DATA_OP_WIDTH-1:0] res_x, res_y;
    logic accept, rot;
    assign accept = (state_q == IDLE) && i_valid;
    assign rot = (func_q == '0);
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        func_d = func_q;
        flip_d = flip_q;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        ox_d = ox_q;
        oy_d = oy_q;
        oz_d = oz_q;
        case (state_q)
            IDLE: if (i_valid) begin
                state_d = MUL;
                idx_d = IW'(GAIN_WIDTH - 1);
                func_d = i_func;
                flip_d = i_flip;
                x_d = i_x;
                y_d = i_y;
                z_d = i_z;
            end
            MUL: begin
                idx_d = idx_q - 1'b1;
                state_d = (idx_q == '0) ? ROUND : MUL;
            end
            ROUND: begin
                state_d = DONE;
                // flip undoes the upstream pi pre-rotation; vectoring keeps the raw residual y
                ox_d = (rot && flip_q) ? -res_x : res_x;
                oy_d = !rot ? y_q : flip_q ? -res_y : res_y;
                oz_d = z_q;
            end
            DONE: state_d = i_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            func_q <= '0;
            flip_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
            oz_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            func_q <= func_d;
            flip_q <= flip_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            oz_q <= oz_d;
        end
    end
    cordic_serial_mul #(.DATA_OP_WIDTH(DATA_OP_WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_mul_x (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(accept), .i_en(state_q == MUL),
        .i_bit(INV_GAIN[idx_q]), .i_op(x_q), .o_res(res_x)
    );
    cordic_serial_mul #(.DATA_OP_WIDTH(DATA_OP_WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_mul_y (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(accept), .i_en(state_q == MUL),
        .i_bit(INV_GAIN[idx_q]), .i_op(y_q), .o_res(res_y)
    );
    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_x = ox_q;
    assign o_y = oy_q;
    assign o_z = oz_q;
endmodule

// File: tb/tb_cordic_post.sv
// tb_cordic_post: randomized and directed self-checking bench for cordic_post against an arithmetic model
module tb_cordic_post;
    logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0, i_flip = 1'b0;
    logic [0:0] i_func = '0;
    logic signed [17:0] i_x = '0, i_y = '0, i_z = '0;
    logic o_ready, o_valid;
    logic signed [17:0] o_x, o_y, o_z;
    int vectors = 0, miscompares = 0, cyc = 0;

    cordic_post dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_func(i_func), .i_flip(i_flip), .i_x(i_x), .i_y(i_y), .i_z(i_z),
        .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_y(o_y), .o_z(o_z)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // v * 0.607252935 rounded half toward +inf, as real-number floor(v*G/2^16 + 1/2)
    function automatic logic signed [17:0] scale(input logic signed [17:0] v);
        longint p, q;
        p = longint'(v) * 39797 + 32768;
        q = p / 65536;
        if (p < 0 && q * 65536 != p) q = q - 1;
        return q[17:0];
    endfunction

    task automatic model(input logic f, input logic fl, input logic signed [17:0] x, y, z,
                         output logic signed [17:0] ex, ey, ez);
        ex = scale(x);
        ey = f ? y : scale(y);
        if (!f && fl) begin
            ex = -ex;
            ey = -ey;
        end
        ez = z;
    endtask

    task automatic apply(input string nm, input logic f, input logic fl,
                         input logic signed [17:0] x, y, z);
        logic signed [17:0] ex, ey, ez;
        int lat;
        model(f, fl, x, y, z, ex, ey, ez);
        @(negedge i_clk);
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_before_accept got %b want 1", nm, o_ready);
        end
        i_func = f; i_flip = fl; i_x = x; i_y = y; i_z = z; i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_func = 1'($urandom); i_flip = 1'($urandom);
        i_x = 18'($urandom); i_y = 18'($urandom); i_z = 18'($urandom);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        vectors++;
        if (lat != 17) begin
            miscompares++;
            $display("FAIL %s latency got %0d want 17", nm, lat);
        end
        vectors++;
        if (o_x !== ex || o_y !== ey || o_z !== ez || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s result got x=%0d y=%0d z=%0d rdy=%b want x=%0d y=%0d z=%0d rdy=0",
                     nm, o_x, o_y, o_z, o_ready, ex, ey, ez);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after_transfer got valid=%b ready=%b want 0 1", nm, o_valid, o_ready);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_x !== 0 || o_y !== 0 || o_z !== 0) begin
            miscompares++;
            $display("FAIL reset got valid=%b ready=%b x=%0d y=%0d z=%0d want 0 1 0 0 0",
                     o_valid, o_ready, o_x, o_y, o_z);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_directed;
        apply("rot_unit", 1'b0, 1'b0, 18'sd65536, 18'sd65536, 18'sd777);
        apply("round_small", 1'b0, 1'b0, 18'sd1, -18'sd1, -18'sd5);
        apply("round_min", 1'b0, 1'b0, -18'sd131072, 18'sd0, 18'sd0);
        apply("rot_flip", 1'b0, 1'b1, 18'sd65536, -18'sd65536, 18'sd42);
        apply("vec_flip", 1'b1, 1'b1, 18'sd65536, 18'sd123, -18'sd9);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++)
            apply("random", 1'($urandom), 1'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    endtask

    task automatic test_backpressure;
        logic signed [17:0] ex, ey, ez;
        int lat;
        model(1'b0, 1'b0, 18'sd30000, -18'sd777, 18'sd55, ex, ey, ez);
        @(negedge i_clk);
        i_func = 1'b0; i_flip = 1'b0; i_x = 18'sd30000; i_y = -18'sd777; i_z = 18'sd55; i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_x !== ex || o_y !== ey || o_z !== ez) begin
                miscompares++;
                $display("FAIL backpressure hold%0d got v=%b r=%b x=%0d y=%0d z=%0d want 1 0 %0d %0d %0d",
                         k, o_valid, o_ready, o_x, o_y, o_z, ex, ey, ez);
            end
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure release got valid=%b ready=%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge i_clk);
        i_func = 1'b0; i_flip = 1'b0; i_x = 18'sd1000; i_y = 18'sd2000; i_z = 18'sd3; i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (7) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        vectors++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_x !== 0 || o_y !== 0 || o_z !== 0) begin
            miscompares++;
            $display("FAIL reset_mid got v=%b r=%b x=%0d y=%0d z=%0d want 0 1 0 0 0",
                     o_valid, o_ready, o_x, o_y, o_z);
        end
        seen = 0;
        repeat (25) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid discarded got %0d valid cycles want 0", seen);
        end
        apply("after_reset", 1'b0, 1'b1, -18'sd50000, 18'sd12345, 18'sd99);
    endtask

    task automatic test_back_to_back;
        logic signed [17:0] qx[$], qy[$], qz[$];
        logic signed [17:0] ex, ey, ez;
        int last, results;
        last = -1;
        results = 0;
        @(negedge i_clk);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_func = 1'($urandom); i_flip = 1'($urandom);
        i_x = 18'($urandom); i_y = 18'($urandom); i_z = 18'($urandom);
        for (int c = 0; c < 100; c++) begin
            if (o_valid) begin
                results++;
                vectors++;
                if (qx.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b unexpected result x=%0d", o_x);
                end else begin
                    ex = qx.pop_front(); ey = qy.pop_front(); ez = qz.pop_front();
                    if (o_x !== ex || o_y !== ey || o_z !== ez) begin
                        miscompares++;
                        $display("FAIL b2b result got %0d %0d %0d want %0d %0d %0d",
                                 o_x, o_y, o_z, ex, ey, ez);
                    end
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 19) begin
                        miscompares++;
                        $display("FAIL b2b spacing got %0d want 19", cyc - last);
                    end
                end
                last = cyc;
            end
            if (o_ready) begin
                model(i_func, i_flip, i_x, i_y, i_z, ex, ey, ez);
                qx.push_back(ex); qy.push_back(ey); qz.push_back(ez);
            end else begin
                i_func = 1'($urandom); i_flip = 1'($urandom);
                i_x = 18'($urandom); i_y = 18'($urandom); i_z = 18'($urandom);
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        vectors++;
        if (results < 4) begin
            miscompares++;
            $display("FAIL b2b result_count got %0d want >=4", results);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
